// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider.
// Holds the FSM state type, the default operand width and the width of the
// iteration counter (wide enough to hold the value WIDTH).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_WIDTH = 8;

    // Counter must reach WIDTH, hence clog2(WIDTH+1).
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/addsub_prefix.sv
// Combinational N-bit add/subtract built on a Brent-Kung parallel-prefix
// carry network.
// Ports:
//   a, b : operands (N bits)
//   sub  : 1 -> a - b (b inverted, carry-in forced to 1); 0 -> a + b
//   sum  : result modulo 2**N
module addsub_prefix #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    localparam int LG = $clog2(N);

    logic [N-1:0] bx;
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] gg;
    logic [N-1:0] pp;

    always_comb begin
        bx = sub ? ~b : b;
        p  = a ^ bx;
        g  = a & bx;
        gg = g;
        pp = p;
        // Carry-in folded into bit 0's generate so the tree sees no cin.
        gg[0] = g[0] | (p[0] & sub);

        // Up-sweep: build group (g,p) at positions 2^k-1 spans.
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end

        // Down-sweep: fill in the remaining prefixes.
        for (int d = (1 << (LG - 1)); d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end

        // gg[i] is the carry out of bit i; carry into bit 0 is sub.
        sum = p ^ {gg[N-2:0], sub};
    end

endmodule

// File: rtl/nonrestoring_divider_8bit.sv
// Sequential unsigned divider, non-restoring algorithm, one add/subtract per
// cycle. Latency from the start-accept edge to done is WIDTH+3 cycles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, sampled only in IDLE
//   dividend, divisor   : operands, captured on accept
//   busy                : state is not IDLE
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   dbz                 : divide-by-zero flag
// Optional build macro DIV_ZERO_DETECT_EN: a zero divisor bypasses the
// iterations and finishes one cycle after accept with dbz=1. Without it,
// dbz is tied to 0 and a zero divisor runs the normal iterations.
module nonrestoring_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, nxt;
    logic [WIDTH:0]   r_q;       // signed partial remainder
    logic [WIDTH-1:0] q_q;       // dividend bits shifting out, quotient bits in
    logic [WIDTH:0]   d_q;       // zero-extended divisor
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic             last;
    logic [WIDTH:0]   add_a;
    logic             add_sub;
    logic [WIDTH:0]   sum;

    assign last = (cnt == CW'(WIDTH));

    // CALC feeds the shifted {R,Q}; FIX reuses the adder for the R+D fixup.
    assign add_a   = (state == CALC) ? {r_q[WIDTH-1:0], q_q[WIDTH-1]} : r_q;
    assign add_sub = (state == CALC) && !r_q[WIDTH];

    addsub_prefix #(.N(WIDTH + 1)) u_addsub (
        .a   (add_a),
        .b   (d_q),
        .sub (add_sub),
        .sum (sum)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    nxt = (divisor == '0) ? DONE : CALC;
`else
                    nxt = CALC;
`endif
                end
            end
            CALC:    if (last) nxt = FIX;
            FIX:     nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        r_q <= '0;
                        q_q <= dividend;
                        d_q <= {1'b0, divisor};
                        cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            quot_q <= '1;
                            rem_q  <= dividend;
                        end
`endif
                    end
                end
                CALC: begin
                    // The cycle with cnt==WIDTH only moves on to FIX.
                    if (!last) begin
                        r_q <= sum;
                        q_q <= {q_q[WIDTH-2:0], ~sum[WIDTH]};
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (r_q[WIDTH]) r_q <= sum;
                    quot_q <= q_q;
                    rem_q  <= r_q[WIDTH] ? sum[WIDTH-1:0] : r_q[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      dbz_q <= 1'b0;
        else if (state == IDLE && start) dbz_q <= (divisor == '0);
    end
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_nonrestoring_divider_8bit.sv
module tb_nonrestoring_divider_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    int checks   = 0;
    int failures = 0;

    nonrestoring_divider_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer division from the stated rules.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction
    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction
    function automatic int ref_lat(input int b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 0) ? 1 : 11;
`else
        return 11;
`endif
    endfunction
    function automatic logic ref_dbz(input int b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request and measure cycles (accept = cycle 0) until done.
    // Optionally scrambles the operand inputs while busy.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input bit scramble, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        if (scramble) begin
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
        end
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (scramble) begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b dbz=%b expected 0 0 0", busy, done, dbz);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL reset_results: q=%0d r=%0d expected 0 0", quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int ta [4] = '{200, 255, 5, 100};
        int tb [4] = '{7, 1, 9, 0};
        int lat;
        for (int k = 0; k < 4; k++) begin
            do_op(8'(ta[k]), 8'(tb[k]), 1'b0, lat);
            checks++;
            if (lat !== ref_lat(tb[k])) begin
                failures++;
                $display("FAIL dir_latency %0d/%0d: got %0d expected %0d", ta[k], tb[k], lat, ref_lat(tb[k]));
            end
            checks++;
            if (quotient !== 8'(ref_q(ta[k], tb[k])) || remainder !== 8'(ref_r(ta[k], tb[k]))) begin
                failures++;
                $display("FAIL dir_result %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                         ta[k], tb[k], quotient, remainder, ref_q(ta[k], tb[k]), ref_r(ta[k], tb[k]));
            end
            checks++;
            if (dbz !== ref_dbz(tb[k])) begin
                failures++;
                $display("FAIL dir_dbz %0d/%0d: got %b expected %b", ta[k], tb[k], dbz, ref_dbz(tb[k]));
            end
            // done is a single pulse; results and dbz hold afterwards
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL dir_pulse %0d/%0d: done=%b busy=%b expected 0 0", ta[k], tb[k], done, busy);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (quotient !== 8'(ref_q(ta[k], tb[k])) || remainder !== 8'(ref_r(ta[k], tb[k]))
                || dbz !== ref_dbz(tb[k])) begin
                failures++;
                $display("FAIL dir_hold %0d/%0d: q=%0d r=%0d dbz=%b", ta[k], tb[k], quotient, remainder, dbz);
            end
        end
    endtask

    task automatic test_random();
        int a, b, lat;
        for (int k = 0; k < 25; k++) begin
            a = int'($urandom_range(0, 255));
            b = (k % 6 == 0) ? 0 : int'($urandom_range(1, 255));
            do_op(8'(a), 8'(b), 1'b1, lat);
            checks++;
            if (lat !== ref_lat(b) || quotient !== 8'(ref_q(a, b)) || remainder !== 8'(ref_r(a, b))
                || dbz !== ref_dbz(b)) begin
                failures++;
                $display("FAIL rand %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b expected lat=%0d q=%0d r=%0d dbz=%b",
                         a, b, lat, quotient, remainder, dbz, ref_lat(b), ref_q(a, b), ref_r(a, b), ref_dbz(b));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busy_ok;
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                dividend = 8'd9;
                divisor  = 8'd9;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (!busy_ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy: busy dropped before done (busy=%b at done)", busy);
        end
        checks++;
        if (lat !== 11 || quotient !== 8'd16 || remainder !== 8'd2) begin
            failures++;
            $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d expected lat=11 q=16 r=2", lat, quotient, remainder);
        end
        // start during the DONE cycle is ignored
        dividend = 8'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL done_start_ignored: busy=%b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || quotient !== 8'd16 || remainder !== 8'd2) begin
            failures++;
            $display("FAIL done_start_hold: busy=%b q=%0d r=%0d expected 0 16 2", busy, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_op(8'd200, 8'd7, 1'b0, lat);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                     busy, done, dbz, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd17, 8'd4, 1'b0, lat);
        checks++;
        if (lat !== 11 || quotient !== 8'd4 || remainder !== 8'd1 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_op: got lat=%0d q=%0d r=%0d dbz=%b expected lat=11 q=4 r=1 dbz=0",
                     lat, quotient, remainder, dbz);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
